// File: rtl/jtag_mem_loader_if.sv
// rtl/jtag_mem_loader_if.sv - serial load link and memory write-port bundle
interface jtag_mem_loader_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          Jen;
    logic [DW-1:0] Jin;
    logic [DW-1:0] Jout;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cores_hold;
    logic          load_done;
    logic          overflow;

    modport master (
        output Jen, Jin,
        input  Jout, dmem_we, dmem_addr, dmem_wdata,
        input  imem_we, imem_addr, imem_wdata,
        input  cores_hold, load_done, overflow
    );

    modport slave (
        input  Jen, Jin,
        output Jout, dmem_we, dmem_addr, dmem_wdata,
        output imem_we, imem_addr, imem_wdata,
        output cores_hold, load_done, overflow
    );
endinterface

// File: rtl/jtag_mem_loader.sv
// rtl/jtag_mem_loader.sv - serial word loader: DEPTH data words then DEPTH instruction words
module jtag_mem_loader #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    jtag_mem_loader_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    localparam int            ADDR_MAX_I = DEPTH - 1;
    localparam int            LAST_I     = 2 * DEPTH - 1;
    localparam logic [AW-1:0] ADDR_MAX   = ADDR_MAX_I[AW-1:0];
    localparam logic [AW:0]   LAST_CNT   = LAST_I[AW:0];

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] jout_q, jout_d;
    logic          dmem_we_q, dmem_we_d;
    logic [AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [DW-1:0] dmem_wdata_q, dmem_wdata_d;
    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [DW-1:0] imem_wdata_q, imem_wdata_d;
    logic          overflow_q, overflow_d;
    logic          accept;
    logic [AW-1:0] waddr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        jout_d       = jout_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        overflow_d   = overflow_q;
        accept       = 1'b0;
        // Memories fill top-down; the low bits restart at ADDR_MAX when the phase bit flips.
        waddr        = ADDR_MAX - cnt_q[AW-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.Jen) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.Jen) begin
                    accept = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.Jen) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            cnt_d  = cnt_q + 1'b1;
            jout_d = bus.Jin;
            if (cnt_q[AW]) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = waddr;
                imem_wdata_d = bus.Jin;
            end else begin
                dmem_we_d    = 1'b1;
                dmem_addr_d  = waddr;
                dmem_wdata_d = bus.Jin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            jout_q       <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            jout_q       <= jout_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.Jout       = jout_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cores_hold = (state_q == S_LOAD);
    assign bus.load_done  = (state_q == S_DONE);
    assign bus.overflow   = overflow_q;
endmodule
